// File: rtl/serial_mem_target.sv
// serial_mem_target: byte-memory responder on the serial initiator bus.
// Define ERR_RESP_EN to flag out-of-window offsets with bus_target_err.
module serial_mem_target #(
  parameter logic [15:0] BASE_ADDR  = 16'h8000,
  parameter logic [15:0] ADDR_MASK  = 16'hF000,
  parameter int          MEM_AW     = 8,
  parameter int          TURNAROUND = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic bus_data_in,
  input  logic bus_data_in_valid,
  input  logic bus_mode,
  input  logic bus_init_rw,
  input  logic bus_init_ready,
  output logic bus_data_out,
  output logic bus_data_out_valid,
  output logic bus_target_ready,
  output logic bus_target_rw,
  output logic bus_target_ack
`ifdef ERR_RESP_EN
  ,
  output logic bus_target_err
`endif
);

  localparam int WW =
    (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;
  localparam logic [WW-1:0] WAIT_LAST =
    WW'(TURNAROUND - 1);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    RD_WAIT,
    RD_SEND,
    ACK
  } state_e;

  state_e state_q, state_d;

  logic [14:0]       addr_sr_q, addr_sr_d;
  logic [6:0]        wd_sr_q, wd_sr_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [WW-1:0]     wait_q, wait_d;
  logic [2:0]        bit_q, bit_d;
  logic [MEM_AW-1:0] off_q, off_d;
  logic [7:0]        rd_q, rd_d;
  logic              rw_q, rw_d;
  logic              match_q, match_d;
  logic              oor_q, oor_d;

  logic [7:0] mem_q [2**MEM_AW];

  logic        in_a, in_d;
  logic [15:0] addr_full;
  logic [7:0]  wd_full;
  logic        hit, oor;
  logic        addr_last, data_last;
  logic        wr_en;

  assign in_a = bus_data_in_valid & bus_mode;
  assign in_d = bus_data_in_valid & ~bus_mode;

  // LSB-first: newest bit enters at the top
  assign addr_full = {bus_data_in, addr_sr_q};
  assign wd_full   = {bus_data_in, wd_sr_q};

  assign hit = (addr_full & ADDR_MASK) == BASE_ADDR;

`ifdef ERR_RESP_EN
  assign oor = |(addr_full[11:0] >> MEM_AW);
`else
  assign oor = 1'b0;
`endif

  assign addr_last = (state_q == ADDR)
                   & in_a & (cnt_q == 4'd15);
  assign data_last = (state_q == WDATA)
                   & in_d & (cnt_q == 4'd7);
  assign wr_en = data_last & match_q & ~oor_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (in_a) state_d = ADDR;
      end
      ADDR: begin
        if (in_d) begin
          state_d = IDLE;
        end else if (addr_last) begin
          if (bus_init_rw)  state_d = WDATA;
          else if (hit)     state_d = RD_WAIT;
          else              state_d = IDLE;
        end
      end
      WDATA: begin
        if (in_a) begin
          state_d = IDLE;
        end else if (data_last) begin
          state_d = match_q ? ACK : IDLE;
        end
      end
      RD_WAIT: begin
        if (wait_q == WAIT_LAST) state_d = RD_SEND;
      end
      RD_SEND: begin
        if (bus_init_ready && bit_q == 3'd7)
          state_d = ACK;
      end
      ACK: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus_target_ready   = 1'b0;
    bus_data_out_valid = 1'b0;
    bus_data_out       = 1'b0;
    bus_target_ack     = 1'b0;
    unique case (state_q)
      IDLE, ADDR, WDATA: bus_target_ready = 1'b1;
      RD_SEND: begin
        bus_data_out_valid = bus_init_ready;
        bus_data_out = bus_init_ready & rd_q[bit_q];
      end
      ACK: bus_target_ack = 1'b1;
      default: ;
    endcase
  end

  assign bus_target_rw = rw_q;

`ifdef ERR_RESP_EN
  assign bus_target_err = (state_q == ACK) & oor_q;
`endif

  always_comb begin
    addr_sr_d = addr_sr_q;
    wd_sr_d   = wd_sr_q;
    cnt_d     = '0;
    wait_d    = '0;
    bit_d     = '0;
    off_d     = off_q;
    rd_d      = rd_q;
    rw_d      = rw_q;
    match_d   = match_q;
    oor_d     = oor_q;
    unique case (state_q)
      IDLE: begin
        if (in_a) begin
          addr_sr_d = addr_full[15:1];
          cnt_d     = 4'd1;
        end
      end
      ADDR: begin
        if (in_a) begin
          addr_sr_d = addr_full[15:1];
          cnt_d     = cnt_q + 4'd1;
        end else if (!in_d) begin
          cnt_d = cnt_q;
        end
        if (addr_last) begin
          off_d   = addr_full[MEM_AW-1:0];
          rw_d    = bus_init_rw;
          match_d = hit;
          oor_d   = oor;
        end
      end
      WDATA: begin
        if (in_d) begin
          wd_sr_d = wd_full[7:1];
          cnt_d   = cnt_q + 4'd1;
        end else if (!in_a) begin
          cnt_d = cnt_q;
        end
      end
      RD_WAIT: begin
        wait_d = wait_q + WW'(1);
        rd_d   = oor_q ? 8'hFF : mem_q[off_q];
      end
      RD_SEND: begin
        bit_d = bus_init_ready ? bit_q + 3'd1 : bit_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_sr_q <= '0;
      wd_sr_q   <= '0;
      cnt_q     <= '0;
      wait_q    <= '0;
      bit_q     <= '0;
      off_q     <= '0;
      rd_q      <= '0;
      rw_q      <= 1'b0;
      match_q   <= 1'b0;
      oor_q     <= 1'b0;
    end else begin
      addr_sr_q <= addr_sr_d;
      wd_sr_q   <= wd_sr_d;
      cnt_q     <= cnt_d;
      wait_q    <= wait_d;
      bit_q     <= bit_d;
      off_q     <= off_d;
      rd_q      <= rd_d;
      rw_q      <= rw_d;
      match_q   <= match_d;
      oor_q     <= oor_d;
    end
  end

  // Storage is deliberately left unreset
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[off_q] <= wd_full;
  end

endmodule

// File: tb/tb_serial_mem_target.sv
// tb_serial_mem_target: random serial-bus traffic against a byte-array model.
// Responses are queued on issue and matched by an independent monitor.
module tb_serial_mem_target;

  localparam int TA = 2;
`ifdef ERR_RESP_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  typedef struct {
    bit         is_rd;
    logic [7:0] data;
    bit         rw;
    bit         err;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic din, din_v, mode, irw, rdy_i;
  logic dout, dvalid, tready, rw, ack;
`ifdef ERR_RESP_EN
  logic err;
`endif

  int   cyc = 0;
  int   vec = 0;
  int   miscmp = 0;
  exp_t sb[$];

  logic [7:0] mem_m [256];
  bit         wr_m [256];
  logic [7:0] offs[$];

  int         nbits = 0;
  int         age = 0;
  int         last_cyc = 0;
  int         exp_c;
  logic [7:0] rx;
  exp_t       hd;

  int p_from = -1;
  int p_to = -2;
  bit rand_rdy = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_mem_target dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .bus_data_in        (din),
    .bus_data_in_valid  (din_v),
    .bus_mode           (mode),
    .bus_init_rw        (irw),
    .bus_init_ready     (rdy_i),
    .bus_data_out       (dout),
    .bus_data_out_valid (dvalid),
    .bus_target_ready   (tready),
    .bus_target_rw      (rw),
    .bus_target_ack     (ack)
`ifdef ERR_RESP_EN
    ,
    .bus_target_err     (err)
`endif
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] want);
    vec++;
    if (act !== want) begin
      miscmp++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)",
               nm, act, want, cyc);
    end
  endtask

  // initiator flow control
  initial begin
    rdy_i = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (cyc >= p_from && cyc <= p_to)
        rdy_i = 1'b0;
      else if (rand_rdy)
        rdy_i = ($urandom_range(0, 3) != 0);
      else
        rdy_i = 1'b1;
    end
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_outputs",
          32'({tready, dvalid, dout, ack, rw}),
          32'(5'b10000));
`ifdef ERR_RESP_EN
      chk("reset_err", 32'(err), 32'(0));
`endif
      nbits = 0;
      age = 0;
    end else if (sb.size() == 0) begin
      chk("idle_ready", 32'(tready), 32'(1));
      chk("stray_valid", 32'(dvalid), 32'(0));
      chk("stray_ack", 32'(ack), 32'(0));
    end else begin
      hd = sb[0];
      age++;
      if (hd.is_rd) begin
        if (cyc < hd.cyc) begin
          chk("rd_early_valid", 32'(dvalid), 32'(0));
        end else begin
          chk("rd_valid_vs_ready", 32'(dvalid), 32'(rdy_i));
          chk("rd_target_busy", 32'(tready), 32'(0));
        end
        chk("rd_no_ack", 32'(ack), 32'(0));
        if (dvalid) begin
          rx[nbits] = dout;
          nbits++;
          last_cyc = cyc;
          if (nbits == 8) begin
            chk("rd_byte", 32'(rx), 32'(hd.data));
            void'(sb.pop_front());
            nbits = 0;
            age = 0;
          end
        end
      end else begin
        exp_c = (hd.cyc < 0) ? last_cyc + 1 : hd.cyc;
        chk("ack_no_valid", 32'(dvalid), 32'(0));
        if (cyc < exp_c) begin
          chk("ack_early", 32'(ack), 32'(0));
        end else begin
          chk("ack_time", 32'(ack), 32'(1));
          if (ack) begin
            chk("ack_rw", 32'(rw), 32'(hd.rw));
            chk("ack_target_busy", 32'(tready), 32'(0));
`ifdef ERR_RESP_EN
            chk("ack_err", 32'(err), 32'(hd.err));
`endif
          end
          void'(sb.pop_front());
          age = 0;
        end
      end
      if (age > 400) begin
        vec++;
        miscmp++;
        $display("FAIL response_timeout: got nothing, want %s",
                 hd.is_rd ? "read byte" : "ack");
        sb.delete();
        nbits = 0;
        age = 0;
      end
    end
  end

  task automatic idle1();
    @(posedge clk);
    #1;
    din_v = 1'b0;
    din   = 1'($urandom);
    mode  = 1'($urandom);
    irw   = 1'($urandom);
  endtask

  task automatic send(input logic b, input logic m,
                      input logic r, output int c);
    if ($urandom_range(0, 3) == 0) idle1();
    @(posedge clk);
    #1;
    din_v = 1'b1;
    din   = b;
    mode  = m;
    irw   = r;
    c     = cyc;
  endtask

  task automatic rel();
    @(posedge clk);
    #1;
    din_v = 1'b0;
  endtask

  // ab: -1 none, 0..15 mode=0 bit instead of addr bit, 16..23 mode=1 bit in data
  task automatic txn(input logic [15:0] a, input bit w,
                     input logic [7:0] d, input int ab);
    int   c;
    exp_t e;
    bit   hit, oor;
    hit = (a[15:12] == 4'h8);
    oor = ERR && (a[11:8] != 4'h0);
    for (int i = 0; i < 16; i++) begin
      if (ab == i) begin
        send(1'($urandom), 1'b0, 1'b0, c);
        rel();
        return;
      end
      send(a[i], 1'b1, (i == 15) ? w : 1'($urandom), c);
    end
    if (w) begin
      for (int j = 0; j < 8; j++) begin
        if (ab == 16 + j) begin
          send(1'($urandom), 1'b1, 1'($urandom), c);
          rel();
          return;
        end
        send(d[j], 1'b0, 1'($urandom), c);
      end
      if (hit) begin
        if (!oor) begin
          mem_m[a[7:0]] = d;
          if (!wr_m[a[7:0]]) begin
            wr_m[a[7:0]] = 1'b1;
            offs.push_back(a[7:0]);
          end
        end
        e.is_rd = 1'b0;
        e.data  = 8'h00;
        e.rw    = 1'b1;
        e.err   = oor;
        e.cyc   = c + 1;
        sb.push_back(e);
      end
    end else if (hit) begin
      e.is_rd = 1'b1;
      e.data  = oor ? 8'hFF : mem_m[a[7:0]];
      e.rw    = 1'b0;
      e.err   = 1'b0;
      e.cyc   = c + 1 + TA;
      sb.push_back(e);
      e.is_rd = 1'b0;
      e.data  = 8'h00;
      e.err   = oor;
      e.cyc   = -1;
      sb.push_back(e);
    end
    rel();
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 600 && sb.size() != 0; n++)
      @(posedge clk);
  endtask

  initial begin
    int         c;
    logic [7:0] pd;
    logic [15:0] pa;
    din_v = 1'b0;
    din   = 1'b0;
    mode  = 1'b0;
    irw   = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    txn(16'h800A, 1'b1, 8'h5C, -1);
    wait_idle();
    txn(16'h800A, 1'b0, 8'h00, -1);
    wait_idle();
    txn(16'h400A, 1'b1, 8'h11, -1);
    wait_idle();
    txn(16'h8001, 1'b1, 8'h55, 10);
    txn(16'h8001, 1'b1, 8'h33, -1);
    wait_idle();

    // hold initiator ready low for 3 cycles after bit 3
    txn(16'h800A, 1'b0, 8'h00, -1);
    for (int n = 0; n < 200 && nbits != 4; n++) begin
      @(posedge clk);
      #1;
    end
    p_from = cyc;
    p_to   = cyc + 2;
    wait_idle();

    txn(16'h8044, 1'b1, 8'h77, -1);
    wait_idle();
    txn(16'h8F44, 1'b1, 8'hA5, -1);
    wait_idle();
    txn(16'h8F44, 1'b0, 8'h00, -1);
    wait_idle();
    txn(16'h8044, 1'b0, 8'h00, -1);
    wait_idle();

    // reset in the middle of a write data phase
    pa = 16'h8001;
    pd = 8'hEE;
    for (int i = 0; i < 16; i++)
      send(pa[i], 1'b1, (i == 15) ? 1'b1 : 1'b0, c);
    for (int j = 0; j < 5; j++)
      send(pd[j], 1'b0, 1'b0, c);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    din_v = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    txn(16'h8001, 1'b0, 8'h00, -1);
    wait_idle();

    for (int t = 0; t < 150; t++) begin
      int          k;
      logic [15:0] a;
      logic [7:0]  d;
      k = $urandom_range(0, 9);
      d = 8'($urandom);
      a = {4'h8,
           ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0,
           8'($urandom)};
      if ($urandom_range(0, 5) == 0)
        send(1'($urandom), 1'b0, 1'($urandom), c);
      if ((k == 4 || k == 5) && offs.size() == 0) k = 0;
      case (k)
        0, 1, 2, 3: txn(a, 1'b1, d, -1);
        4, 5: begin
          a[7:0] = offs[$urandom_range(0, offs.size() - 1)];
          rand_rdy = 1'b1;
          txn(a, 1'b0, 8'h00, -1);
          wait_idle();
          rand_rdy = 1'b0;
        end
        6: txn(16'($urandom), 1'b1, d, -1);
        7: txn({1'b0, 15'($urandom)}, 1'b0, 8'h00, -1);
        8: txn(a, 1'($urandom), d, $urandom_range(0, 15));
        default: txn(a, 1'b1, d, $urandom_range(16, 23));
      endcase
      wait_idle();
    end

    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             vec, miscmp);
    $finish;
  end

endmodule
